lives_manager: RTL

Game-state controller for the monkey's lives and the heart icons on the HUD. It counts lives down on collision hits and up on bonus pickups, and runs a frame-counted invulnerability window after each hit. It drives one draw-enable per heart bitmap, blinking the heart being lost during that window, and raises game-over when the last life is gone. It sits between the collision/game logic and the heart bitmap instances, which gate their drawing requests with `heartEnable[i]`.

---
 rtl/lives_manager_if.sv | 39 +++
 rtl/lives_manager.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lives_manager_if.sv
// Lives manager bus: game-logic pulses in, lives/HUD state out.
// Master is the game logic, slave is lives_manager.
interface lives_manager_if #(
  parameter int MAX_LIVES = 3
);
  logic                 startOfFrame;
  logic                 newGame;
  logic                 hitRequest;
  logic                 extraLife;
  logic [1:0]           numOfLives;
  logic [MAX_LIVES-1:0] heartEnable;
  logic                 invulnerable;
  logic                 lifeLost;
  logic                 gameOver;

  modport master (
    output startOfFrame,
    output newGame,
    output hitRequest,
    output extraLife,
    input  numOfLives,
    input  heartEnable,
    input  invulnerable,
    input  lifeLost,
    input  gameOver
  );

  modport slave (
    input  startOfFrame,
    input  newGame,
    input  hitRequest,
    input  extraLife,
    output numOfLives,
    output heartEnable,
    output invulnerable,
    output lifeLost,
    output gameOver
  );
endinterface

// File: rtl/lives_manager.sv
// Lives counter, post-hit invulnerability window and heart blinking.
// All outputs are registered; newGame outranks every other input.
module lives_manager #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic            clk,
  input  logic            resetN,
  lives_manager_if.slave  bus
);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0] MAX_L = 2'(MAX_LIVES);
  localparam logic [7:0] INV_F = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLK_P = 8'(BLINK_PERIOD);

  state_t               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [7:0]           frame_q, frame_d;
  logic [7:0]           blink_q, blink_d;
  logic                 phase_q, phase_d;
  logic [1:0]           idx_q, idx_d;
  logic                 rest_q, rest_d;
  logic                 lost_q, lost_d;
  logic [MAX_LIVES-1:0] heart_q, heart_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= PLAY;
      lives_q <= MAX_L;
      frame_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      rest_q  <= 1'b0;
      lost_q  <= 1'b0;
      heart_q <= '1;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      rest_q  <= rest_d;
      lost_q  <= lost_d;
      heart_q <= heart_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    frame_d = frame_q;
    blink_d = blink_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    rest_d  = rest_q;
    lost_d  = 1'b0;
    if (bus.newGame) begin
      state_d = PLAY;
      lives_d = MAX_L;
      frame_d = '0;
      blink_d = '0;
      phase_d = 1'b0;
      idx_d   = '0;
      rest_d  = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (bus.hitRequest) begin
            lives_d = lives_q - 2'd1;
            lost_d  = 1'b1;
            if (lives_d == 2'd0) begin
              state_d = GAME_OVER;
            end else begin
              state_d = INVULN;
              frame_d = INV_F;
              blink_d = BLK_P;
              phase_d = 1'b0;
              idx_d   = lives_d;
              rest_d  = 1'b0;
            end
          end else if (bus.extraLife && lives_q < MAX_L) begin
            lives_d = lives_q + 2'd1;
          end
        end
        INVULN: begin
          if (bus.extraLife && lives_q < MAX_L) begin
            lives_d = lives_q + 2'd1;
            if (lives_d > idx_q) rest_d = 1'b1;
          end
          if (bus.startOfFrame) begin
            if (blink_q <= 8'd1) begin
              phase_d = ~phase_q;
              blink_d = BLK_P;
            end else begin
              blink_d = blink_q - 8'd1;
            end
            if (frame_q <= 8'd1) begin
              state_d = PLAY;
              frame_d = '0;
              blink_d = '0;
              phase_d = 1'b0;
            end else begin
              frame_d = frame_q - 8'd1;
            end
          end
        end
        GAME_OVER: ;
        default: state_d = PLAY;
      endcase
    end
  end

  // Hearts follow the next-state values so they stay aligned with lives.
  always_comb begin
    heart_d = '0;
    if (state_d != GAME_OVER) begin
      for (int i = 0; i < MAX_LIVES; i++) begin
        heart_d[i] = (2'(i) < lives_d);
        if (state_d == INVULN && !rest_d && 2'(i) == idx_d)
          heart_d[i] = phase_d;
      end
    end
  end

  assign bus.numOfLives   = lives_q;
  assign bus.heartEnable  = heart_q;
  assign bus.invulnerable = (state_q == INVULN);
  assign bus.lifeLost     = lost_q;
  assign bus.gameOver     = (state_q == GAME_OVER);

endmodule
